// File: rtl/datapath_p2.sv
// ----------------------------------------------------------------------------
// datapath_p2
// 32-bit single-bus CPU datapath for the phase-2 processor. An external
// control sequencer drives every strobe; this block only holds the registers,
// the bus multiplexer, the register-select/encode logic, the C sign-extender,
// the CON flip-flop and the ALU.
//
// Ports
//   Clock       in   1  rising-edge clock for all registers
//   Clear       in   1  active-low asynchronous reset of every register
//   outp        out 32  current bus value
//   PCout..InPortout     in 1  bus-source enables (priority ordered below)
//   MARin..OutPortin     in 1  register load enables
//   IncPC       in   1  ALU computes bus+1 regardless of opcode
//   Read        in   1  MDR input mux selects Mdatain instead of the bus
//   Write       in   1  memory write request (consumed outside this block)
//   Gra/Grb/Grc in   1  select Ra / Rb / Rc field of IR
//   Rin/Rout    in   1  load / drive the selected general register
//   BAout       in   1  drive the selected register, R0 reads as zero
//   Cout        in   1  drive sign-extended IR[18:0]
//   CONIn       in   1  load the CON flip-flop
//   Strobe      in   1  load InPort from Mdatain
//   Mdatain     in  32  memory read data
// ----------------------------------------------------------------------------
module datapath_p2 (
    input  logic        Clock,
    input  logic        Clear,
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        CONIn,
    input  logic        Strobe,
    input  logic [31:0] Mdatain
);

    // ALU opcodes taken from IR[31:27]; anything not listed adds.
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10011;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0] r_regs [16];
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_inport;
    logic [31:0] r_outport;
    logic        r_con;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [31:0] w_bus;
    logic [3:0]  w_rsel;
    logic [31:0] w_reg_rd;
    logic [31:0] w_c_sext;
    logic [4:0]  w_op;
    logic [4:0]  w_sh;
    logic [63:0] w_alu;
    logic [63:0] w_mul;
    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic [31:0] w_div_b;
    logic        w_div_ovf;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_ror_wide;
    logic [63:0] w_rol_wide;
    logic        w_con_d;
    logic        w_unused;

    // Select/encode: the enabled IR fields are OR-ed into one register index.
    assign w_rsel = ({4{Gra}} & r_ir[26:23])
                  | ({4{Grb}} & r_ir[22:19])
                  | ({4{Grc}} & r_ir[18:15]);

    assign w_reg_rd = r_regs[w_rsel];
    assign w_c_sext = {{13{r_ir[18]}}, r_ir[18:0]};

    // Bus multiplexer, highest priority first. BAout differs from Rout only
    // in that an R0 selection reads as zero (base-address semantics).
    always_comb begin
        w_bus = 32'h0;
        if (Rout) begin
            w_bus = w_reg_rd;
        end else if (BAout) begin
            w_bus = (w_rsel == 4'd0) ? 32'h0 : w_reg_rd;
        end else if (PCout) begin
            w_bus = r_pc;
        end else if (Zhiout) begin
            w_bus = r_z[63:32];
        end else if (Zlowout) begin
            w_bus = r_z[31:0];
        end else if (MDRout) begin
            w_bus = r_mdr;
        end else if (HIout) begin
            w_bus = r_hi;
        end else if (LOout) begin
            w_bus = r_lo;
        end else if (InPortout) begin
            w_bus = r_inport;
        end else if (Cout) begin
            w_bus = w_c_sext;
        end
    end

    assign outp = w_bus;

    // ------------------------------------------------------------------
    // ALU: A = Y, B = bus
    // ------------------------------------------------------------------
    assign w_op = r_ir[31:27];
    assign w_sh = w_bus[4:0];

    assign w_a_sx = {{32{r_y[31]}}, r_y};
    assign w_b_sx = {{32{w_bus[31]}}, w_bus};
    assign w_mul  = w_a_sx * w_b_sx;

    // The divider never sees a zero divisor or the single overflowing pair
    // (-2^31 / -1); those cases are resolved by the result mux instead.
    assign w_div_ovf = (r_y == 32'h8000_0000) && (w_bus == 32'hFFFF_FFFF);
    assign w_div_b   = ((w_bus == 32'h0) || w_div_ovf) ? 32'd1 : w_bus;
    assign w_quot    = 32'($signed(r_y) / $signed(w_div_b));
    assign w_rem     = 32'($signed(r_y) % $signed(w_div_b));

    // Rotates are taken from a doubled copy of A shifted by the amount.
    assign w_ror_wide = {r_y, r_y} >> w_sh;
    assign w_rol_wide = {r_y, r_y} << w_sh;

    always_comb begin
        w_alu = {32'h0, r_y + w_bus};
        if (IncPC) begin
            w_alu = {32'h0, w_bus + 32'd1};
        end else begin
            case (w_op)
                OP_SUB:          w_alu = {32'h0, r_y - w_bus};
                OP_AND, OP_ANDI: w_alu = {32'h0, r_y & w_bus};
                OP_OR,  OP_ORI:  w_alu = {32'h0, r_y | w_bus};
                OP_SHR:          w_alu = {32'h0, r_y >> w_sh};
                OP_SHRA:         w_alu = {32'h0, 32'($signed(r_y) >>> w_sh)};
                OP_SHL:          w_alu = {32'h0, r_y << w_sh};
                OP_ROR:          w_alu = {32'h0, w_ror_wide[31:0]};
                OP_ROL:          w_alu = {32'h0, w_rol_wide[63:32]};
                OP_MUL:          w_alu = w_mul;
                OP_DIV: begin
                    if (w_bus == 32'h0) begin
                        w_alu = 64'h0;
                    end else if (w_div_ovf) begin
                        w_alu = {32'h0, 32'h8000_0000};
                    end else begin
                        w_alu = {w_rem, w_quot};
                    end
                end
                OP_NEG:          w_alu = {32'h0, 32'h0 - w_bus};
                OP_NOT:          w_alu = {32'h0, ~w_bus};
                default:         w_alu = {32'h0, r_y + w_bus};
            endcase
        end
    end

    // CON condition evaluated on the bus value, condition code in IR[20:19].
    always_comb begin
        case (r_ir[20:19])
            2'b00:   w_con_d = (w_bus == 32'h0);
            2'b01:   w_con_d = (w_bus != 32'h0);
            2'b10:   w_con_d = ~w_bus[31];
            default: w_con_d = w_bus[31];
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (Rin) begin
            r_regs[w_rsel] <= w_bus;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_pc      <= 32'h0;
            r_ir      <= 32'h0;
            r_mar     <= 32'h0;
            r_mdr     <= 32'h0;
            r_y       <= 32'h0;
            r_z       <= 64'h0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_inport  <= 32'h0;
            r_outport <= 32'h0;
            r_con     <= 1'b0;
        end else begin
            if (PCin)      r_pc      <= w_bus;
            if (IRin)      r_ir      <= w_bus;
            if (MARin)     r_mar     <= w_bus;
            if (MDRin)     r_mdr     <= Read ? Mdatain : w_bus;
            if (Yin)       r_y       <= w_bus;
            if (Zin)       r_z       <= w_alu;
            if (HIin)      r_hi      <= w_bus;
            if (LOin)      r_lo      <= w_bus;
            if (Strobe)    r_inport  <= Mdatain;
            if (OutPortin) r_outport <= w_bus;
            if (CONIn)     r_con     <= w_con_d;
        end
    end

    // MAR, OutPort and CON feed logic outside this block (memory, pins, the
    // sequencer via hierarchy); Write is only passed through to memory.
    assign w_unused = ^{Write, r_mar, r_outport, r_con};

endmodule

// File: tb/tb_datapath_p2.sv
module tb_datapath_p2;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
    logic [31:0] Mdatain;

    datapath_p2 dut (
        .Clock(Clock), .Clear(Clear), .outp(outp),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .CONIn(CONIn), .Strobe(Strobe), .Mdatain(Mdatain)
    );

    always #5 Clock = ~Clock;

    // Observation points: 0 bus, 1 CON, 2 OutPort, 3 MAR, 4 IR
    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    logic chk_req = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: pops the expectation posted for this cycle and compares it
    // against the selected observation point, mid-cycle.
    always @(negedge Clock) begin
        chk_t        c;
        logic [31:0] act;
        if (chk_req) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_underflow: got empty queue, required an entry");
            end else begin
                c = sb_q.pop_front();
                case (c.src)
                    1:       act = {31'h0, dut.r_con};
                    2:       act = dut.r_outport;
                    3:       act = dut.r_mar;
                    4:       act = dut.r_ir;
                    default: act = outp;
                endcase
                if (act !== c.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %08h required %08h", c.name, act, c.exp);
                end else begin
                    $display("ok   %s: %08h", c.name, act);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clr_ctrl();
        {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        chk_req = 1'b0;
        clr_ctrl();
    endtask

    task automatic expect_val(input string name, input int src, input logic [31:0] exp);
        sb_q.push_back('{name, src, exp});
        chk_req = 1'b1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1; tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v); MDRout = 1; IRin = 1; tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v); MDRout = 1; Yin = 1; tick();
    endtask

    task automatic alu_check(input string name, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] lo, input logic [31:0] hi);
        logic [26:0] rest;
        rest = 27'($urandom);
        load_ir({op, rest});
        load_y(a);
        load_mdr(b);
        MDRout = 1; Zin = 1; tick();
        Zlowout = 1; expect_val({name, "_zlo"}, 0, lo); tick();
        Zhiout = 1;  expect_val({name, "_zhi"}, 0, hi); tick();
    endtask

    // Reference ALU in 64-bit integer arithmetic.
    function automatic logic [63:0] alu_ref(input logic [4:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, m;
        longint sa, sb;
        int n;
        ua = 64'(a); ub = 64'(b); m = 64'hFFFF_FFFF;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        n  = int'(b[4:0]);
        case (op)
            5'd4:        return (ua - ub) & m;
            5'd5, 5'd13: return ua & ub;
            5'd6, 5'd14: return ua | ub;
            5'd7:        return ua >> n;
            5'd8:        return 64'(sa >>> n) & m;
            5'd9:        return (ua << n) & m;
            5'd10:       return ((ua >> n) | (ua << (32 - n))) & m;
            5'd11:       return ((ua << n) | (ua >> (32 - n))) & m;
            5'd15:       return 64'(sa * sb);
            5'd16: begin
                if (b == 0) return 64'h0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            5'd17:       return (64'h0 - ub) & m;
            5'd19:       return (~ub) & m;
            default:     return (ua + ub) & m;
        endcase
    endfunction

    function automatic logic con_ref(input logic [1:0] cond, input logic [31:0] v);
        case (cond)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return v[31] == 1'b0;
            default: return v[31] == 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] m_regs [16];
    logic [31:0] ir_v, val;
    logic [63:0] z_exp;
    logic [4:0]  op_r;
    logic [31:0] con_vals [3];

    initial begin
        clr_ctrl();
        Mdatain = 32'h0;
        Clear = 1'b0;
        tick(); tick();
        Clear = 1'b1;

        // Reset state
        PCout = 1; expect_val("reset_pc", 0, 32'h0); tick();
        expect_val("idle_bus_zero", 0, 32'h0); tick();
        expect_val("reset_ir", 4, 32'h0); tick();

        // Register file: random writes through Rc, reads through Ra/Rb
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        for (int it = 0; it < 12; it++) begin
            ir_v = $urandom;
            load_ir(ir_v);
            val = $urandom;
            load_mdr(val);
            MDRout = 1; Grc = 1; Rin = 1; tick();
            m_regs[ir_v[18:15]] = val;
            Gra = 1; Rout = 1;  expect_val("rf_ra_rout", 0, m_regs[ir_v[26:23]]); tick();
            Gra = 1; BAout = 1;
            expect_val("rf_ra_baout", 0, (ir_v[26:23] == 4'd0) ? 32'h0 : m_regs[ir_v[26:23]]);
            tick();
            Grb = 1; Rout = 1;  expect_val("rf_rb_rout", 0, m_regs[ir_v[22:19]]); tick();
        end

        // Mid-run reset with PC=5
        load_mdr(32'd5);
        MDRout = 1; PCin = 1; tick();
        PCout = 1; expect_val("pc_before_clear", 0, 32'd5); tick();
        PCout = 1; #2 Clear = 1'b0;
        expect_val("clear_async_bus", 0, 32'h0); tick();
        Clear = 1'b1;
        PCout = 1; expect_val("pc_after_clear", 0, 32'h0); tick();

        // Fetch
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h9118_0023;
        expect_val("fetch_zlo", 0, 32'd1); tick();
        MDRout = 1; IRin = 1; tick();
        expect_val("fetch_ir", 4, 32'h9118_0023); tick();
        PCout = 1; expect_val("fetch_pc", 0, 32'd1); tick();
        Cout = 1; expect_val("c_sext_pos", 0, 32'd35); tick();

        // brmi R2,35 taken
        load_mdr(32'hFFFF_FFF0);
        MDRout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; Rout = 1; CONIn = 1; expect_val("brmi_r2", 0, 32'hFFFF_FFF0); tick();
        expect_val("brmi_con_taken", 1, 32'd1); tick();
        PCout = 1; Yin = 1; tick();
        Cout = 1; Zin = 1; tick();
        Zlowout = 1; PCin = 1; expect_val("brmi_target", 0, 32'd36); tick();
        PCout = 1; MARin = 1; expect_val("brmi_pc", 0, 32'd36); tick();
        expect_val("mar_load", 3, 32'd36); tick();
        // brmi with R2=5 not taken
        load_mdr(32'd5);
        MDRout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; Rout = 1; CONIn = 1; tick();
        expect_val("brmi_con_not_taken", 1, 32'd0); tick();

        // All condition codes over zero / positive / negative bus values
        con_vals[0] = 32'h0; con_vals[1] = 32'd5; con_vals[2] = 32'h8000_0000;
        for (int cc = 0; cc < 4; cc++) begin
            load_ir({5'b10010, 4'd0, 2'b00, 2'(cc), 19'd0});
            for (int k = 0; k < 3; k++) begin
                load_mdr(con_vals[k]);
                MDRout = 1; CONIn = 1; tick();
                expect_val("con_cond", 1, {31'h0, con_ref(2'(cc), con_vals[k])}); tick();
            end
        end

        // Sign extension with IR[18]=1
        load_ir(32'h0004_7FFF);
        Cout = 1; expect_val("c_sext_neg", 0, 32'hFFFC_7FFF); tick();

        // Directed ALU cases
        alu_check("sub", 5'b00100, 32'd7, 32'd10, 32'hFFFF_FFFD, 32'h0);
        alu_check("mul", 5'b01111, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'hFFFF_FFFF);
        alu_check("div", 5'b10000, 32'd17, 32'd5, 32'd3, 32'd2);
        alu_check("div0", 5'b10000, 32'd17, 32'd0, 32'd0, 32'd0);
        alu_check("div_ovf", 5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        alu_check("add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h0);

        // Random ALU cases against the reference model
        for (int it = 0; it < 40; it++) begin
            op_r = 5'($urandom_range(0, 31));
            ir_v = $urandom;
            val  = $urandom;
            if (it % 5 == 0) val = val & 32'h1F;
            z_exp = alu_ref(op_r, ir_v, val);
            alu_check($sformatf("alu_op%0d", op_r), op_r, ir_v, val, z_exp[31:0], z_exp[63:32]);
        end

        // BAout masks R0
        load_ir(32'h2000_0000);
        load_mdr(32'h55);
        MDRout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; BAout = 1; expect_val("baout_r0", 0, 32'h0); tick();
        Gra = 1; Rout = 1;  expect_val("rout_r0", 0, 32'h55); tick();

        // InPort / OutPort / HI / LO
        Mdatain = 32'hABCD; Strobe = 1; tick();
        Mdatain = 32'h0;
        InPortout = 1; expect_val("inport", 0, 32'hABCD); tick();
        load_mdr(32'h12);
        MDRout = 1; OutPortin = 1; tick();
        expect_val("outport", 2, 32'h12); tick();
        load_mdr(32'hCAFE_0001);
        MDRout = 1; HIin = 1; tick();
        load_mdr(32'h0000_1234);
        MDRout = 1; LOin = 1; tick();
        HIout = 1; expect_val("hi", 0, 32'hCAFE_0001); tick();
        LOout = 1; expect_val("lo", 0, 32'h0000_1234); tick();

        // Bus priority
        PCout = 1; MDRout = 1; Cout = 1; expect_val("prio_pc_over_mdr", 0, 32'd36); tick();
        HIout = 1; LOout = 1; InPortout = 1; expect_val("prio_hi_over_lo", 0, 32'hCAFE_0001); tick();
        LOout = 1; InPortout = 1; expect_val("prio_lo_over_in", 0, 32'h0000_1234); tick();

        // Source and load of the same register in one cycle
        load_mdr(32'd100);
        MDRout = 1; Zin = 1; IncPC = 1; tick();
        Zlowout = 1; Zin = 1; IncPC = 1; expect_val("z_self_pre", 0, 32'd101); tick();
        Zlowout = 1; expect_val("z_self_post", 0, 32'd102); tick();

        tick(); tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
